// File: rtl/risc_v_32_pkg.sv
// Shared definitions for the RV32 memory-access stage: funct3 size codes,
// FSM state type and bus-lane helpers.
package risc_v_32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, WAIT} state_t;

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   be_of = 4'b0001 << a;
      2'b01:   be_of = 4'b0011 << {a[1], 1'b0};
      default: be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   wdata_of = {4{sd[7:0]}};
      2'b01:   wdata_of = {2{sd[15:0]}};
      default: wdata_of = sd;
    endcase
  endfunction

  // Covers conflicting read/write, unsupported size codes and misalignment.
  function automatic logic illegal_of(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [1:0] a);
    logic bad_ld, bad_st, mis;
    bad_ld = rd && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    bad_st = wr && !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    mis    = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    illegal_of = (rd && wr) || bad_ld || bad_st || ((rd || wr) && mis);
  endfunction

endpackage

// File: rtl/risc_v_32_load_align.sv
// Extracts the addressed byte/half/word from a read bus word and extends it.
module risc_v_32_load_align
  import risc_v_32_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      F3_W:    o_data = i_rdata;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/risc_v_32_mem.sv
// RV32 MEM stage: runs loads/stores on the data bus, stalls until ack and
// registers the MEM/WB entry for the write-back mux.
module risc_v_32_mem
  import risc_v_32_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       alu_out_i,
  input  logic [31:0]       store_data_i,
  input  logic [2:0]        funct3_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_write_i,
  input  logic [4:0]        rd_i,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [31:0]       mem_out,
  output logic [31:0]       alu_out,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic [4:0]        rd,
  output logic              mem_exc
);

  state_t      r_state;
  logic [31:0] r_q_alu;
  logic [2:0]  r_q_f3;
  logic        r_q_load;
  logic        r_q_we;
  logic [3:0]  r_q_be;
  logic [31:0] r_q_wdata;
  logic        r_q_m2r;
  logic        r_q_rw;
  logic [4:0]  r_q_rd;

  logic        r_wb_valid;
  logic [31:0] r_mem_out;
  logic [31:0] r_alu_out;
  logic        r_m2r;
  logic        r_rw;
  logic [4:0]  r_rd;
  logic        r_exc;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_illegal;
  logic [31:0] w_load_data;

  assign in_ready  = (r_state == IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_is_mem  = mem_read_i || mem_write_i;
  assign w_illegal = illegal_of(mem_read_i, mem_write_i, funct3_i, alu_out_i[1:0]);

  risc_v_32_load_align u_align (
    .i_rdata   (dmem_rdata),
    .i_funct3  (r_q_f3),
    .i_addr_lo (r_q_alu[1:0]),
    .o_data    (w_load_data)
  );

  // Request fields live in r_q_* so the MEM/WB outputs stay untouched while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_q_alu    <= '0;
      r_q_f3     <= '0;
      r_q_load   <= 1'b0;
      r_q_we     <= 1'b0;
      r_q_be     <= '0;
      r_q_wdata  <= '0;
      r_q_m2r    <= 1'b0;
      r_q_rw     <= 1'b0;
      r_q_rd     <= '0;
      r_wb_valid <= 1'b0;
      r_mem_out  <= '0;
      r_alu_out  <= '0;
      r_m2r      <= 1'b0;
      r_rw       <= 1'b0;
      r_rd       <= '0;
      r_exc      <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_exc      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_is_mem || w_illegal) begin
              r_wb_valid <= 1'b1;
              r_exc      <= w_illegal;
              r_mem_out  <= '0;
              r_alu_out  <= alu_out_i;
              r_m2r      <= mem_to_reg_i;
              r_rw       <= reg_write_i;
              r_rd       <= rd_i;
            end else begin
              r_q_alu   <= alu_out_i;
              r_q_f3    <= funct3_i;
              r_q_load  <= mem_read_i;
              r_q_we    <= mem_write_i;
              r_q_be    <= be_of(funct3_i, alu_out_i[1:0]);
              r_q_wdata <= wdata_of(funct3_i, store_data_i);
              r_q_m2r   <= mem_to_reg_i;
              r_q_rw    <= reg_write_i;
              r_q_rd    <= rd_i;
              r_state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            r_wb_valid <= 1'b1;
            r_mem_out  <= r_q_load ? w_load_data : '0;
            r_alu_out  <= r_q_alu;
            r_m2r      <= r_q_m2r;
            r_rw       <= r_q_rw;
            r_rd       <= r_q_rd;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem_req   = (r_state == WAIT);
  assign dmem_we    = dmem_req && r_q_we;
  assign dmem_addr  = {r_q_alu[ADDR_W-1:2], 2'b00};
  assign dmem_be    = r_q_be;
  assign dmem_wdata = r_q_wdata;

  assign wb_valid = r_wb_valid;
  assign mem_out  = r_mem_out;
  assign alu_out  = r_alu_out;
  assign MemtoReg = r_m2r;
  assign rd       = r_rd;
  assign mem_exc  = r_exc;
  assign RegWrite = r_rw && r_wb_valid && !r_exc;

endmodule

// File: tb/tb_risc_v_32_mem.sv
// Directed bench for risc_v_32_mem: vector table of single transactions plus
// reset-in-WAIT and back-to-back sequences.
module tb_risc_v_32_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_out_i = '0;
  logic [31:0] store_data_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic        mem_to_reg_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [4:0]  rd_i = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        wb_valid;
  logic [31:0] mem_out;
  logic [31:0] alu_out;
  logic        MemtoReg;
  logic        RegWrite;
  logic [4:0]  rd;
  logic        mem_exc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  risc_v_32_mem #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out_i(alu_out_i), .store_data_i(store_data_i), .funct3_i(funct3_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_to_reg_i(mem_to_reg_i), .reg_write_i(reg_write_i), .rd_i(rd_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_valid(wb_valid), .mem_out(mem_out),
    .alu_out(alu_out), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .rd(rd),
    .mem_exc(mem_exc)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [2:0]  f3;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
    logic [4:0]  rdn;
    logic [31:0] rdata;
    int          dly;
    logic        exc;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mout;
    logic        regw;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                       input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic [4:0] r);
    alu_out_i = a; store_data_i = sd; funct3_i = f3;
    mem_read_i = mr; mem_write_i = mw; mem_to_reg_i = m2r;
    reg_write_i = rw; rd_i = r; in_valid = 1'b1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   reqc;
    int   exp_lat;
    int   exp_reqc;
    bit   done;
    string p;
    v = vecs[i];
    p = $sformatf("v%0d", i);
    exp_lat  = (v.exc || !(v.mr || v.mw)) ? 1 : v.dly + 2;
    exp_reqc = (v.exc || !(v.mr || v.mw)) ? 0 : v.dly + 1;
    @(negedge clk);
    chk({p, ".idle_wb"}, {31'd0, wb_valid}, 32'd0);
    chk({p, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    drive(v.alu, v.sd, v.f3, v.mr, v.mw, v.m2r, v.rw, v.rdn);
    @(negedge clk);
    in_valid = 1'b0;
    reqc = 0;
    done = 1'b0;
    for (int n = 1; n <= 20 && !done; n++) begin
      if (dmem_req) begin
        if (reqc == 0) begin
          chk({p, ".addr"}, dmem_addr, {v.alu[31:2], 2'b00});
          chk({p, ".be"}, {28'd0, dmem_be}, {28'd0, v.be});
          chk({p, ".wdata"}, dmem_wdata, v.wdata);
          chk({p, ".we"}, {31'd0, dmem_we}, {31'd0, v.mw});
        end
        chk({p, ".stall"}, {31'd0, in_ready}, 32'd0);
        reqc++;
        if (reqc == v.dly + 1) begin
          dmem_ack = 1'b1;
          dmem_rdata = v.rdata;
        end else begin
          dmem_ack = 1'b0;
          dmem_rdata = 32'hDEAD_0000;
        end
      end
      if (wb_valid) begin
        done = 1'b1;
        dmem_ack = 1'b0;
        chk({p, ".latency"}, n, exp_lat);
        chk({p, ".req_cycles"}, reqc, exp_reqc);
        chk({p, ".mem_out"}, mem_out, v.mout);
        chk({p, ".alu_out"}, alu_out, v.alu);
        chk({p, ".rd"}, {27'd0, rd}, {27'd0, v.rdn});
        chk({p, ".MemtoReg"}, {31'd0, MemtoReg}, {31'd0, v.m2r});
        chk({p, ".mem_exc"}, {31'd0, mem_exc}, {31'd0, v.exc});
        chk({p, ".RegWrite"}, {31'd0, RegWrite}, {31'd0, v.regw});
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      dmem_ack = 1'b0;
      chk({p, ".timeout"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    //          alu           sd            f3      mr mw m2r rw rd  rdata         dly exc be       wdata         mout          regw
    vecs[0]  = '{32'h0000_1234, 32'h0,       3'b000, 0, 0, 0, 1, 5,  32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1};
    vecs[1]  = '{32'h0000_0103, 32'h0,       3'b000, 1, 0, 1, 1, 1,  32'h80FF_0000, 0, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1};
    vecs[2]  = '{32'h0000_0103, 32'h0,       3'b100, 1, 0, 1, 1, 2,  32'h80FF_0000, 0, 0, 4'b1000, 32'h0,        32'h0000_0080, 1};
    vecs[3]  = '{32'h0000_0202, 32'h0000_ABCD, 3'b001, 0, 1, 0, 0, 0,  32'h0,      3, 0, 4'b1100, 32'hABCD_ABCD, 32'h0,        0};
    vecs[4]  = '{32'h0000_0301, 32'h0,       3'b010, 1, 0, 1, 1, 3,  32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0};
    vecs[5]  = '{32'h0000_0102, 32'h0,       3'b001, 1, 0, 1, 1, 4,  32'h8001_1234, 1, 0, 4'b1100, 32'h0,        32'hFFFF_8001, 1};
    vecs[6]  = '{32'h0000_0100, 32'h0,       3'b101, 1, 0, 1, 1, 6,  32'h8001_F234, 0, 0, 4'b0011, 32'h0,        32'h0000_F234, 1};
    vecs[7]  = '{32'h0000_0001, 32'h1234_56AB, 3'b000, 0, 1, 0, 0, 0,  32'h0,      0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0,        0};
    vecs[8]  = '{32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 0, 1, 0, 0, 0,  32'h0,      2, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0};
    vecs[9]  = '{32'h0000_0020, 32'h0,       3'b010, 1, 0, 1, 1, 31, 32'h1234_5678, 0, 0, 4'b1111, 32'h0,        32'h1234_5678, 1};
    vecs[10] = '{32'h0000_0040, 32'h0,       3'b010, 1, 1, 1, 1, 8,  32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0};
    vecs[11] = '{32'h0000_0044, 32'h0,       3'b100, 0, 1, 0, 1, 9,  32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0};
    vecs[12] = '{32'h0000_0048, 32'h0,       3'b011, 1, 0, 1, 1, 10, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0};
    vecs[13] = '{32'h0000_0203, 32'h0,       3'b001, 0, 1, 0, 1, 11, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0};
    vecs[14] = '{32'h0000_0007, 32'h0,       3'b000, 1, 0, 1, 1, 12, 32'h0000_0000, 1, 0, 4'b1000, 32'h0,        32'h0,        1};

    #12;
    chk("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst.dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("rst.RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("rst.alu_out", alu_out, 32'd0);
    chk("rst.mem_out", mem_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(i);

    // Reset while a load waits on the bus.
    @(negedge clk);
    drive(32'h0000_0040, 32'h0, 3'b010, 1, 0, 1, 1, 7);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstw.req_before", {31'd0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw.req_dropped", {31'd0, dmem_req}, 32'd0);
    chk("rstw.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h5555_5555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rstw.no_wb%0d", k), {31'd0, wb_valid}, 32'd0);
      chk($sformatf("rstw.no_req%0d", k), {31'd0, dmem_req}, 32'd0);
    end
    dmem_ack = 1'b0;
    chk("rstw.in_ready_after", {31'd0, in_ready}, 32'd1);

    // Back-to-back: LW 0x0 with zero-wait ack, then ADD accepted on the wb_valid cycle.
    @(negedge clk);
    drive(32'h0000_0000, 32'h0, 3'b010, 1, 0, 1, 1, 3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b.req", {31'd0, dmem_req}, 32'd1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("b2b.wb1", {31'd0, wb_valid}, 32'd1);
    chk("b2b.mem_out1", mem_out, 32'hCAFE_F00D);
    chk("b2b.rd1", {27'd0, rd}, 32'd3);
    chk("b2b.ready1", {31'd0, in_ready}, 32'd1);
    drive(32'h0000_0055, 32'h0, 3'b000, 0, 0, 0, 1, 7);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b.wb2", {31'd0, wb_valid}, 32'd1);
    chk("b2b.alu2", alu_out, 32'h0000_0055);
    chk("b2b.mem_out2", mem_out, 32'd0);
    chk("b2b.rd2", {27'd0, rd}, 32'd7);
    chk("b2b.regw2", {31'd0, RegWrite}, 32'd1);
    chk("b2b.noreq", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    chk("b2b.wb_end", {31'd0, wb_valid}, 32'd0);
    chk("b2b.hold_alu", alu_out, 32'h0000_0055);
    chk("b2b.regw_gated", {31'd0, RegWrite}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
